// File: rtl/adpll_lock_seq_pkg.sv
// Shared definitions for the ADPLL lock sequencer: register map, port widths and FSM encodings.
package adpll_lock_seq_pkg;

    localparam int unsigned FCWW         = 28;
    localparam int unsigned ADPLL_ADDR_W = 8;

    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_EN    = 8'h00;
    localparam logic [ADPLL_ADDR_W-1:0] FCW         = 8'h04;
    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_MODE  = 8'h08;
    localparam logic [ADPLL_ADDR_W-1:0] ADPLL_LOCK  = 8'h0C;
    localparam logic [ADPLL_ADDR_W-1:0] DCO_PD_TEST = 8'h10;
    localparam logic [ADPLL_ADDR_W-1:0] TDC_PD_TEST = 8'h14;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_TDC_PU,
        S_W_DCO_PU,
        S_W_FCW,
        S_W_MODE,
        S_W_EN,
        S_SETTLE,
        S_POLL,
        S_GAP,
        S_W_DIS,
        S_LOCKED,
        S_SUP_GAP,
        S_SUP_POLL,
        S_W_DCO_PD,
        S_W_TDC_PD,
        S_FAIL
    } state_e;

    // Why the loop is being disabled decides where W_DIS goes next.
    typedef enum logic [1:0] {
        WHY_TIMEOUT,
        WHY_RELOCK,
        WHY_STOP
    } dis_why_e;

endpackage

// File: rtl/adpll_lock_seq_bus.sv
// One-shot register-port engine: launches a single access while req is held and reports done on ready.
module adpll_seq_bus
    import adpll_lock_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [ADPLL_ADDR_W-1:0] addr,
    input  logic [31:0]             data,
    input  logic                    we,
    output logic                    done,
    output logic                    rbit,
    output logic                    valid,
    output logic [ADPLL_ADDR_W-1:0] address,
    output logic [31:0]             wdata,
    output logic                    wstrb,
    input  logic                    rdata_bit0,
    input  logic                    ready
);

    logic                    wait_q, wait_d;
    logic [ADPLL_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]             data_q, data_d;
    logic                    we_q, we_d;

    always_comb begin
        wait_d = wait_q;
        addr_d = addr_q;
        data_d = data_q;
        we_d   = we_q;
        if (!wait_q && req) begin
            wait_d = 1'b1;
            addr_d = addr;
            data_d = data;
            we_d   = we;
        end else if (wait_q && ready) begin
            wait_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
        end else begin
            wait_q <= wait_d;
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
        end
    end

    // The launch cycle drives the request directly so a write costs two cycles; the
    // latched copy then holds address/strobe until ready.
    assign valid   = req && !wait_q;
    assign address = valid ? addr : addr_q;
    assign wdata   = valid ? data : data_q;
    assign wstrb   = valid ? we : we_q;
    assign done    = wait_q && ready;
    assign rbit    = rdata_bit0;

endmodule

// File: rtl/adpll_lock_seq.sv
// ADPLL lock sequencer: powers up, programs and enables the loop, acquires and supervises lock.
module adpll_lock_seq
    import adpll_lock_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYC   = 64,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned POLL_GAP     = 16,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [FCWW-1:0]         fcw_in,
    input  logic [1:0]              mode_in,
    output logic                    valid,
    output logic [ADPLL_ADDR_W-1:0] address,
    output logic [31:0]             wdata,
    output logic                    wstrb,
    input  logic [31:0]             rdata,
    input  logic                    ready,
    output logic                    busy,
    output logic                    locked,
    output logic                    fail,
    output logic                    lost_lock,
    output logic [1:0]              retry_cnt
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(POLL_GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT     = CNT_W'(LOCK_TIMEOUT);

    state_e            state_q, state_d;
    dis_why_e          why_q, why_d;
    logic              stop_pend_q, stop_pend_d;
    logic              down_fail_q, down_fail_d;
    logic              lost_q, lost_d;
    logic [1:0]        retry_q, retry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  gap_q, gap_d;
    logic [FCWW-1:0]   fcw_q, fcw_d;
    logic [1:0]        mode_q, mode_d;

    logic                    req, we, done, rbit;
    logic [ADPLL_ADDR_W-1:0] req_addr;
    logic [31:0]             req_data;
    logic                    acq_bus, quiet_wait, stop_eff;
    logic                    rdata_unused;

    assign rdata_unused = ^rdata[31:1];
    assign acq_bus      = state_q inside {S_W_TDC_PU, S_W_DCO_PU, S_W_FCW, S_W_MODE,
                                          S_W_EN, S_POLL, S_SUP_POLL};
    assign quiet_wait   = state_q inside {S_SETTLE, S_GAP, S_LOCKED, S_SUP_GAP};
    assign stop_eff     = stop || stop_pend_q;

    always_comb begin
        state_d     = state_q;
        why_d       = why_q;
        stop_pend_d = stop_pend_q;
        down_fail_d = down_fail_q;
        lost_d      = 1'b0;
        retry_d     = retry_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        fcw_d       = fcw_q;
        mode_d      = mode_q;
        req         = 1'b0;
        we          = 1'b1;
        req_addr    = '0;
        req_data    = '0;

        case (state_q)
            S_W_TDC_PU: begin req = 1'b1; req_addr = TDC_PD_TEST; end
            S_W_DCO_PU: begin req = 1'b1; req_addr = DCO_PD_TEST; end
            S_W_FCW:    begin req = 1'b1; req_addr = FCW;        req_data = 32'(fcw_q);  end
            S_W_MODE:   begin req = 1'b1; req_addr = ADPLL_MODE; req_data = 32'(mode_q); end
            S_W_EN:     begin req = 1'b1; req_addr = ADPLL_EN;   req_data = 32'd1; end
            S_W_DIS:    begin req = 1'b1; req_addr = ADPLL_EN; end
            S_W_DCO_PD: begin req = 1'b1; req_addr = DCO_PD_TEST; req_data = 32'd1; end
            S_W_TDC_PD: begin req = 1'b1; req_addr = TDC_PD_TEST; req_data = 32'd1; end
            S_POLL, S_SUP_POLL: begin req = 1'b1; we = 1'b0; req_addr = ADPLL_LOCK; end
            default: ;
        endcase

        // Lock-acquire counter spans SETTLE/POLL/GAP and saturates.
        if ((state_q inside {S_SETTLE, S_POLL, S_GAP}) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_FAIL: begin
                if (stop && state_q == S_FAIL) begin
                    state_d = S_IDLE;
                end else if (start && !stop) begin
                    fcw_d       = fcw_in;
                    mode_d      = mode_in;
                    retry_d     = '0;
                    down_fail_d = 1'b0;
                    stop_pend_d = 1'b0;
                    state_d     = S_W_TDC_PU;
                end
            end
            S_W_TDC_PU: if (done) state_d = S_W_DCO_PU;
            S_W_DCO_PU: if (done) state_d = S_W_FCW;
            S_W_FCW:    if (done) state_d = S_W_MODE;
            S_W_MODE:   if (done) state_d = S_W_EN;
            S_W_EN: begin
                if (done) begin
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: if (cnt_q == SETTLE_LAST) state_d = S_POLL;
            S_POLL: begin
                if (done) begin
                    gap_d = '0;
                    if (rbit) begin
                        state_d = S_LOCKED;
                    end else if (cnt_q >= TIMEOUT) begin
                        why_d   = WHY_TIMEOUT;
                        state_d = S_W_DIS;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP, S_SUP_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) state_d = (state_q == S_GAP) ? S_POLL : S_SUP_POLL;
            end
            S_LOCKED: begin
                gap_d   = '0;
                state_d = S_SUP_GAP;
            end
            S_SUP_POLL: begin
                if (done) begin
                    if (rbit) begin
                        state_d = S_LOCKED;
                    end else begin
                        lost_d  = 1'b1;
                        retry_d = '0;
                        why_d   = WHY_RELOCK;
                        state_d = S_W_DIS;
                    end
                end
            end
            S_W_DIS: begin
                if (stop) stop_pend_d = 1'b1;
                if (done) begin
                    if (stop_eff || why_q == WHY_STOP) begin
                        down_fail_d = 1'b0;
                        stop_pend_d = 1'b0;
                        state_d     = S_W_DCO_PD;
                    end else if (why_q == WHY_RELOCK) begin
                        state_d = S_W_EN;
                    end else if (retry_q < 2'(MAX_RETRY)) begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_W_EN;
                    end else begin
                        down_fail_d = 1'b1;
                        state_d     = S_W_DCO_PD;
                    end
                end
            end
            S_W_DCO_PD: begin
                if (stop) down_fail_d = 1'b0;
                if (done) state_d = S_W_TDC_PD;
            end
            S_W_TDC_PD: begin
                if (stop) down_fail_d = 1'b0;
                if (done) state_d = down_fail_d ? S_FAIL : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // stop never abandons an access in flight: remember it and divert once done arrives.
        if (acq_bus) begin
            if (done && stop_eff) begin
                why_d       = WHY_STOP;
                stop_pend_d = 1'b0;
                state_d     = S_W_DIS;
            end else if (stop) begin
                stop_pend_d = 1'b1;
            end
        end else if (quiet_wait && stop) begin
            why_d   = WHY_STOP;
            state_d = S_W_DIS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            why_q       <= WHY_TIMEOUT;
            stop_pend_q <= 1'b0;
            down_fail_q <= 1'b0;
            lost_q      <= 1'b0;
            retry_q     <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            fcw_q       <= '0;
            mode_q      <= '0;
        end else begin
            state_q     <= state_d;
            why_q       <= why_d;
            stop_pend_q <= stop_pend_d;
            down_fail_q <= down_fail_d;
            lost_q      <= lost_d;
            retry_q     <= retry_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            fcw_q       <= fcw_d;
            mode_q      <= mode_d;
        end
    end

    adpll_seq_bus u_bus (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr       (req_addr),
        .data       (req_data),
        .we         (we),
        .done       (done),
        .rbit       (rbit),
        .valid      (valid),
        .address    (address),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .rdata_bit0 (rdata[0]),
        .ready      (ready)
    );

    assign busy      = !(state_q inside {S_IDLE, S_LOCKED, S_FAIL});
    assign locked    = (state_q == S_LOCKED);
    assign fail      = (state_q == S_FAIL);
    assign lost_lock = lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_adpll_lock_seq.sv
// Bench for adpll_lock_seq: register-block model on the bus, vector table, random cases, corner sequences.
module tb_adpll_lock_seq;
    import adpll_lock_seq_pkg::*;

    localparam int unsigned SETTLE  = 8;
    localparam int unsigned TMO     = 64;
    localparam int unsigned GAP     = 4;
    localparam int unsigned RETRIES = 3;
    localparam int          BOUND   = 3000;

    logic                    clk = 1'b0;
    logic                    rst, start, stop;
    logic [FCWW-1:0]         fcw_in;
    logic [1:0]              mode_in;
    logic                    valid, wstrb, ready;
    logic [ADPLL_ADDR_W-1:0] address;
    logic [31:0]             wdata, rdata;
    logic                    busy, locked, fail, lost_lock;
    logic [1:0]              retry_cnt;

    int   lock_after;
    logic lock_kill;
    int   en1_cnt, en0_cnt, lost_cnt;
    logic [39:0] wlog[$];
    logic [39:0] exp_q[$];
    logic        exp_locked;
    logic [1:0]  exp_retry;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    adpll_lock_seq #(
        .SETTLE_CYC   (SETTLE),
        .LOCK_TIMEOUT (TMO),
        .POLL_GAP     (GAP),
        .MAX_RETRY    (RETRIES),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .fcw_in    (fcw_in),
        .mode_in   (mode_in),
        .valid     (valid),
        .address   (address),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .rdata     (rdata),
        .ready     (ready),
        .busy      (busy),
        .locked    (locked),
        .fail      (fail),
        .lost_lock (lost_lock),
        .retry_cnt (retry_cnt)
    );

    // Register block: ready one cycle after valid, lock reported once enough EN=1 writes happened.
    assign rdata = {31'b0, (!lock_kill && (en1_cnt > lock_after))};

    always @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b0;
            en1_cnt  <= 0;
            en0_cnt  <= 0;
            lost_cnt <= 0;
            wlog.delete();
        end else begin
            ready <= valid;
            if (valid && wstrb) begin
                wlog.push_back({address, wdata});
                if (address == ADPLL_EN && wdata == 32'd1) en1_cnt <= en1_cnt + 1;
                if (address == ADPLL_EN && wdata == 32'd0) en0_cnt <= en0_cnt + 1;
            end
            if (lost_lock) lost_cnt <= lost_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; lock_kill = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [FCWW-1:0] f, input logic [1:0] m);
        fcw_in = f; mode_in = m; start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Expected write trace from the sequencing rules: power-up, program, enable, one EN=0/EN=1
    // pair per failed attempt that still has budget, then power-down if the budget runs out.
    function automatic void build_expected(input logic [FCWW-1:0] f, input logic [1:0] m, input int la);
        int tries;
        exp_q.delete();
        exp_q.push_back({TDC_PD_TEST, 32'd0});
        exp_q.push_back({DCO_PD_TEST, 32'd0});
        exp_q.push_back({FCW, 32'(f)});
        exp_q.push_back({ADPLL_MODE, 32'(m)});
        exp_q.push_back({ADPLL_EN, 32'd1});
        tries = (la > int'(RETRIES)) ? int'(RETRIES) : la;
        for (int i = 0; i < tries; i++) begin
            exp_q.push_back({ADPLL_EN, 32'd0});
            exp_q.push_back({ADPLL_EN, 32'd1});
        end
        if (la > int'(RETRIES)) begin
            exp_q.push_back({ADPLL_EN, 32'd0});
            exp_q.push_back({DCO_PD_TEST, 32'd1});
            exp_q.push_back({TDC_PD_TEST, 32'd1});
        end
        exp_locked = (la <= int'(RETRIES));
        exp_retry  = 2'(tries);
    endfunction

    task automatic compare_log(input string tag, input int base);
        check({tag, "_nwrites"}, 64'(wlog.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < wlog.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(wlog[base + i]), 64'(exp_q[i]));
    endtask

    task automatic run_to_end(input string tag);
        int t;
        for (t = 0; t < BOUND && !(locked || fail); t++) step(1);
        check({tag, "_finished"}, 64'(locked || fail), 64'd1);
    endtask

    typedef struct {
        logic [FCWW-1:0] fcw;
        logic [1:0]      mode;
        int              lock_after;
        logic            exp_locked;
        logic            exp_fail;
        logic [1:0]      exp_retry;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int n, base;
        rst = 1'b1; start = 1'b0; stop = 1'b0; lock_kill = 1'b0; lock_after = 0;
        fcw_in = '0; mode_in = '0;

        tbl[0] = '{fcw: 28'h2620000, mode: 2'd1, lock_after: 0, exp_locked: 1'b1, exp_fail: 1'b0, exp_retry: 2'd0};
        tbl[1] = '{fcw: 28'h1234567, mode: 2'd2, lock_after: 1, exp_locked: 1'b1, exp_fail: 1'b0, exp_retry: 2'd1};
        tbl[2] = '{fcw: 28'hFFFFFFF, mode: 2'd3, lock_after: 2, exp_locked: 1'b1, exp_fail: 1'b0, exp_retry: 2'd2};
        tbl[3] = '{fcw: 28'h0000001, mode: 2'd0, lock_after: 3, exp_locked: 1'b1, exp_fail: 1'b0, exp_retry: 2'd3};
        tbl[4] = '{fcw: 28'h2620000, mode: 2'd1, lock_after: 4, exp_locked: 1'b0, exp_fail: 1'b1, exp_retry: 2'd3};

        // Reset values
        rst = 1'b1;
        step(2);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_addr_wdata_wstrb", 64'({address, wdata, wstrb}), 64'd0);
        check("rst_status", 64'({busy, locked, fail, lost_lock, retry_cnt}), 64'd0);
        rst = 1'b0;

        // Table vectors
        for (int v = 0; v < 5; v++) begin
            do_reset();
            lock_after = tbl[v].lock_after;
            pulse_start(tbl[v].fcw, tbl[v].mode);
            run_to_end($sformatf("tbl%0d", v));
            check($sformatf("tbl%0d_locked", v), 64'(locked), 64'(tbl[v].exp_locked));
            check($sformatf("tbl%0d_fail", v), 64'(fail), 64'(tbl[v].exp_fail));
            check($sformatf("tbl%0d_retry", v), 64'(retry_cnt), 64'(tbl[v].exp_retry));
            check($sformatf("tbl%0d_busy", v), 64'(busy), 64'd0);
            build_expected(tbl[v].fcw, tbl[v].mode, tbl[v].lock_after);
            compare_log($sformatf("tbl%0d", v), 0);
        end

        // FAIL is sticky; start while FAIL-less busy is ignored; stop in FAIL returns to IDLE
        step(20);
        check("fail_sticky", 64'(fail), 64'd1);
        base = wlog.size();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_in_fail", 64'({busy, fail, locked}), 64'd0);
        step(4);
        check("stop_in_fail_nowrites", 64'(wlog.size()), 64'(base));

        // Randomized cases against the trace model
        for (int r = 0; r < 8; r++) begin
            logic [FCWW-1:0] f;
            logic [1:0]      m;
            int              la;
            f  = FCWW'($urandom);
            m  = 2'($urandom_range(0, 3));
            la = int'($urandom_range(0, 5));
            do_reset();
            lock_after = la;
            pulse_start(f, m);
            run_to_end($sformatf("rnd%0d", r));
            build_expected(f, m, la);
            check($sformatf("rnd%0d_locked", r), 64'(locked), 64'(exp_locked));
            check($sformatf("rnd%0d_fail", r), 64'(fail), 64'(!exp_locked));
            check($sformatf("rnd%0d_retry", r), 64'(retry_cnt), 64'(exp_retry));
            compare_log($sformatf("rnd%0d", r), 0);
        end

        // Lock latency after the EN=1 write
        do_reset();
        lock_after = 0;
        pulse_start(28'h2620000, 2'd1);
        for (n = 0; n < 200 && !(valid && wstrb && address == ADPLL_EN && wdata == 32'd1); n++) step(1);
        check("en_write_seen", 64'(valid && wstrb && address == ADPLL_EN), 64'd1);
        for (n = 0; n < 400 && !locked; n++) step(1);
        check("lock_latency", 64'(n), 64'(SETTLE + 4));

        // start while LOCKED is ignored
        base = wlog.size();
        pulse_start(28'h1111111, 2'd2);
        step(3);
        check("start_in_locked_ignored", 64'(wlog.size()), 64'(base));

        // Lost lock during supervision: one pulse, EN=0 then EN=1, re-lock with fresh budget
        for (n = 0; n < 100 && !locked; n++) step(1);
        base = wlog.size();
        lock_kill = 1'b1;
        for (n = 0; n < 400 && en0_cnt == 0; n++) step(1);
        check("relock_en0_seen", 64'(en0_cnt), 64'd1);
        lock_kill = 1'b0;
        for (n = 0; n < 400 && !locked; n++) step(1);
        check("relock_locked", 64'(locked), 64'd1);
        check("relock_lost_pulses", 64'(lost_cnt), 64'd1);
        check("relock_retry", 64'(retry_cnt), 64'd0);
        exp_q.delete();
        exp_q.push_back({ADPLL_EN, 32'd0});
        exp_q.push_back({ADPLL_EN, 32'd1});
        compare_log("relock", base);

        // stop in the middle of the FCW write
        do_reset();
        lock_after = 100;
        pulse_start(28'h2620000, 2'd1);
        for (n = 0; n < 100 && !(valid && address == FCW); n++) step(1);
        check("fcw_write_seen", 64'(valid && address == FCW), 64'd1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        for (n = 0; n < 200 && busy; n++) step(1);
        check("stop_idle", 64'({busy, locked, fail}), 64'd0);
        exp_q.delete();
        exp_q.push_back({TDC_PD_TEST, 32'd0});
        exp_q.push_back({DCO_PD_TEST, 32'd0});
        exp_q.push_back({FCW, 32'h2620000});
        exp_q.push_back({ADPLL_EN, 32'd0});
        exp_q.push_back({DCO_PD_TEST, 32'd1});
        exp_q.push_back({TDC_PD_TEST, 32'd1});
        compare_log("stop", 0);

        // Reset during SETTLE
        do_reset();
        lock_after = 0;
        pulse_start(28'h2620000, 2'd1);
        for (n = 0; n < 200 && !(valid && wstrb && address == ADPLL_EN); n++) step(1);
        step(3);
        check("settle_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        step(1);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_bus", 64'({address, wdata, wstrb}), 64'd0);
        check("midrst_status", 64'({busy, locked, fail, lost_lock, retry_cnt}), 64'd0);
        rst = 1'b0;
        step(20);
        check("midrst_stays_idle", 64'({busy, valid}), 64'd0);

        // start and stop together in IDLE
        do_reset();
        fcw_in = 28'h2620000; mode_in = 2'd1;
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(5);
        check("start_stop_idle_busy", 64'(busy), 64'd0);
        check("start_stop_idle_nowrites", 64'(wlog.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
